// File: rtl/present_80.sv
// Iterative PRESENT-80 encryption engine: one round per clock,
// 31 rounds followed by a final whitening step with K32.
module present_80 (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [63:0] indata,
   input  logic [79:0] key,
   output logic [63:0] outdata,
   output logic        done
);

   localparam logic [5:0] RND_IDLE = 6'd0;
   localparam logic [5:0] RND_LAST = 6'd31;
   localparam logic [5:0] RND_FIN  = 6'd32;

   logic [63:0] state_q, state_d;
   logic [79:0] kreg_q, kreg_d;
   logic [5:0]  rnd_q, rnd_d;
   logic [63:0] outdata_q, outdata_d;
   logic        done_q, done_d;

   logic [63:0] round_key;
   logic [63:0] sub_out;
   logic [63:0] perm_out;
   logic [79:0] kreg_next;
   logic        in_round;

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      unique case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         4'hF: y = 4'h2;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int n = 0; n < 16; n++) begin
         y[4*n +: 4] = sbox(x[4*n +: 4]);
      end
      return y;
   endfunction

   // bit j lands on (16*j) mod 63; bit 63 is a fixed point
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] y;
      logic [5:0]  dst;
      y = '0;
      for (int j = 0; j < 63; j++) begin
         dst = 6'((16 * j) % 63);
         y[dst] = x[6'(j)];
      end
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [79:0] key_update(
      input logic [79:0] k,
      input logic [4:0]  rc
   );
      logic [79:0] r;
      r = {k[18:0], k[79:19]};
      r[79:76] = sbox(r[79:76]);
      r[19:15] = r[19:15] ^ rc;
      return r;
   endfunction

   assign round_key = kreg_q[79:16];
   assign sub_out   = s_layer(state_q ^ round_key);
   assign perm_out  = p_layer(sub_out);
   assign kreg_next = key_update(kreg_q, rnd_q[4:0]);
   assign in_round  = (rnd_q != RND_IDLE) && (rnd_q <= RND_LAST);

   always_comb begin
      state_d   = state_q;
      kreg_d    = kreg_q;
      rnd_d     = rnd_q;
      outdata_d = outdata_q;
      done_d    = done_q;
      if (load) begin
         state_d = indata;
         kreg_d  = key;
         rnd_d   = 6'd1;
         done_d  = 1'b0;
      end else if (in_round) begin
         state_d = perm_out;
         kreg_d  = kreg_next;
         rnd_d   = rnd_q + 6'd1;
      end else if (rnd_q == RND_FIN) begin
         outdata_d = state_q ^ round_key;
         done_d    = 1'b1;
         rnd_d     = RND_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= '0;
         kreg_q    <= '0;
         rnd_q     <= RND_IDLE;
         outdata_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         kreg_q    <= kreg_d;
         rnd_q     <= rnd_d;
         outdata_q <= outdata_d;
         done_q    <= done_d;
      end
   end

   assign outdata = outdata_q;
   assign done    = done_q;

endmodule

// File: tb/tb_present_80.sv
// Scoreboard bench for present_80: stimulus queues expected ciphertext
// and completion cycle, a negedge monitor checks each rising done.
module tb_present_80;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic [63:0] indata = '0;
   logic [79:0] key = '0;
   logic [63:0] outdata;
   logic        done;

   typedef struct {
      logic [63:0] ct;
      int          due;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   logic done_prev = 1'b0;

   present_80 dut (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .indata  (indata),
      .key     (key),
      .outdata (outdata),
      .done    (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [79:0] act,
                      input logic [79:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference PRESENT-80, straight from the cipher description
   function automatic logic [63:0] ref_enc(input logic [63:0] pt,
                                           input logic [79:0] k);
      int          sb[16];
      logic [63:0] s;
      logic [63:0] t;
      logic [79:0] kk;
      logic [4:0]  rc;
      sb = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
      s = pt;
      kk = k;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ kk[79:16];
         for (int n = 0; n < 16; n++)
            t[4*n +: 4] = 4'(sb[s[4*n +: 4]]);
         s = '0;
         for (int j = 0; j < 64; j++)
            s[16 * (j % 4) + j / 4] = t[j];
         kk = {kk[18:0], kk[79:19]};
         kk[79:76] = 4'(sb[kk[79:76]]);
         rc = 5'(r);
         kk[19:15] = kk[19:15] ^ rc;
      end
      return s ^ kk[79:16];
   endfunction

   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_done: got outdata %h at cycle %0d expected no done",
                     outdata, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ciphertext", 80'(outdata), 80'(e.ct));
            chk("latency_cycle", 80'(cyc), 80'(e.due));
         end
      end
      done_prev = done;
   end

   task automatic do_load(input logic [63:0] pt, input logic [79:0] k,
                          input int len, input logic [63:0] ct);
      exp_t e;
      @(posedge clk);
      #1;
      exp_q.delete();
      load = 1'b1;
      indata = pt;
      key = k;
      for (int i = 0; i < len; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) chk("done_drop_on_load", 80'(done), 80'(0));
      end
      load = 1'b0;
      e.ct = ct;
      e.due = cyc + 32;
      exp_q.push_back(e);
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++)
         @(negedge clk);
      @(negedge clk);
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL timeout: got no done within %0d cycles expected done", budget);
         exp_q.delete();
      end
   endtask

   logic [63:0] pts[4];
   logic [79:0] keys[2];
   logic [63:0] rpt;
   logic [79:0] rkey;

   initial begin
      // reset held two edges while load toggles
      @(negedge clk);
      load = 1'b1;
      indata = 64'h0123456789abcdef;
      key = 80'h1;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      chk("reset_outdata", 80'(outdata), 80'(0));
      chk("reset_done", 80'(done), 80'(0));
      repeat (40) @(negedge clk);
      chk("idle_after_reset_done", 80'(done), 80'(0));
      chk("idle_after_reset_out", 80'(outdata), 80'(0));

      do_load(64'h0, 80'h0, 1, 64'h5579C1387B228445);
      wait_done(40);
      do_load(64'h0, {80{1'b1}}, 1, 64'hE72C46C0F5945049);
      wait_done(40);
      do_load({64{1'b1}}, 80'h0, 1, 64'hA112FFC72F68417B);
      wait_done(40);
      do_load({64{1'b1}}, {80{1'b1}}, 1, 64'h3333DCD3213210D2);
      wait_done(40);
      repeat (5) @(negedge clk);
      chk("done_holds_idle", 80'(done), 80'(1));
      chk("out_holds_idle", 80'(outdata), 80'(64'h3333DCD3213210D2));

      do_load(64'h0, 80'h0, 7, 64'h5579C1387B228445);
      wait_done(40);

      pts = '{64'h834349fd8e99a23b, 64'h9281dcb8a883a38c,
              64'hd392f4ec58356aeb, 64'h3e5380018fc28d70};
      keys = '{80'h3014f4d8c37d9cc7e689, 80'h88239f8276ec927c8dec};
      foreach (keys[ki])
         foreach (pts[pi]) begin
            do_load(pts[pi], keys[ki], 1, ref_enc(pts[pi], keys[ki]));
            wait_done(40);
         end

      // abort: a second load ten cycles in replaces the first
      do_load(pts[0], keys[0], 1, ref_enc(pts[0], keys[0]));
      repeat (10) @(posedge clk);
      do_load(pts[1], keys[1], 1, ref_enc(pts[1], keys[1]));
      wait_done(45);

      // reset in the middle of round 15
      do_load(pts[2], keys[0], 1, ref_enc(pts[2], keys[0]));
      repeat (14) @(posedge clk);
      #1;
      reset = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("midreset_outdata", 80'(outdata), 80'(0));
      chk("midreset_done", 80'(done), 80'(0));
      repeat (40) @(negedge clk);
      chk("midreset_done_stays", 80'(done), 80'(0));
      do_load(pts[3], keys[1], 1, ref_enc(pts[3], keys[1]));
      wait_done(40);

      for (int it = 0; it < 24; it++) begin
         rpt = {$urandom, $urandom};
         rkey = {$urandom, $urandom, 16'($urandom)};
         do_load(rpt, rkey, $urandom_range(1, 3), ref_enc(rpt, rkey));
         if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 30)) @(posedge clk);
         else
            wait_done(45);
      end
      wait_done(45);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
